// File: rtl/overflow_recombine_unit.sv
// Recombines split MSP/LSP partial sums into one ACCUM_WIDTH accumulation per frame.
// Define OVERFLOW_RECOMBINE_SATURATE_EN to force an all-ones result on an overflowed frame.
module overflow_recombine_unit #(
    parameter int ACCUM_WIDTH = 48,
    parameter int LSP_WIDTH   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACCUM_WIDTH-1:0] in_msp,
    input  logic [ACCUM_WIDTH-1:0] in_lsp,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACCUM_WIDTH-1:0] out_data,
    output logic                   out_overflow,
    output logic [15:0]            out_count,
    output logic [1:0]             dbg_state
);
    localparam int MSP_WIDTH = ACCUM_WIDTH - LSP_WIDTH;

    // Handshakes: a beat moves on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and held output data is stable until it is taken.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

    state_t               state, state_nx;
    logic                 live;
    logic [MSP_WIDTH-1:0] msp_acc;
    logic [LSP_WIDTH-1:0] lsp_acc;
    logic                 ovf;
    logic [15:0]          count;
    logic                 accept, handoff;
    logic [LSP_WIDTH:0]   lsp_sum;
    logic [MSP_WIDTH:0]   msp_sum;
    logic                 unused_bits;

    assign unused_bits = ^{in_msp[ACCUM_WIDTH-1:MSP_WIDTH], in_lsp[ACCUM_WIDTH-1:LSP_WIDTH]};

    // The LSP carry ripples into the MSP add; the MSP carry-out is the overflow.
    assign lsp_sum = {1'b0, lsp_acc} + {1'b0, in_lsp[LSP_WIDTH-1:0]};
    assign msp_sum = {1'b0, msp_acc} + {1'b0, in_msp[MSP_WIDTH-1:0]}
                   + {{MSP_WIDTH{1'b0}}, lsp_sum[LSP_WIDTH]};

    always_comb begin
        state_nx  = state;
        in_ready  = live && (state != HOLD);
        out_valid = (state == HOLD);
        accept    = in_valid && in_ready;
        handoff   = out_valid && out_ready;
        case (state)
            IDLE, ACCUM: begin
                if (accept) state_nx = in_last ? HOLD : ACCUM;
            end
            HOLD: begin
                if (handoff) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // live holds in_ready low for the first cycle after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            live    <= 1'b0;
            msp_acc <= '0;
            lsp_acc <= '0;
            ovf     <= 1'b0;
            count   <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (handoff) begin
                msp_acc <= '0;
                lsp_acc <= '0;
                ovf     <= 1'b0;
                count   <= '0;
            end else if (accept) begin
                lsp_acc <= lsp_sum[LSP_WIDTH-1:0];
                msp_acc <= msp_sum[MSP_WIDTH-1:0];
                ovf     <= ovf | msp_sum[MSP_WIDTH];
                if (count != 16'hFFFF) count <= count + 16'd1;
            end
        end
    end

`ifdef OVERFLOW_RECOMBINE_SATURATE_EN
    assign out_data = ((state == HOLD) && ovf) ? {ACCUM_WIDTH{1'b1}} : {msp_acc, lsp_acc};
`else
    assign out_data = {msp_acc, lsp_acc};
`endif

    assign out_overflow = ovf;
    assign out_count    = count;
    assign dbg_state    = state;

endmodule

// File: tb/tb_overflow_recombine_unit.sv
// Directed bench for overflow_recombine_unit: frames with hand-computed results,
// backpressure, mid-frame reset and the overflow case in both build flavours.
module tb_overflow_recombine_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_msp;
    logic [47:0] in_lsp;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        out_overflow;
    logic [15:0] out_count;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

`ifdef OVERFLOW_RECOMBINE_SATURATE_EN
    localparam logic [47:0] OVF_DATA = 48'hFFFF_FFFF_FFFF;
`else
    localparam logic [47:0] OVF_DATA = 48'h0;
`endif

    overflow_recombine_unit dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_msp       (in_msp),
        .in_lsp       (in_lsp),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_count    (out_count),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a beat at a falling edge and returns just after the edge that takes it.
    task automatic send_beat(input logic [47:0] msp, input logic [47:0] lsp, input logic last);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_msp   = msp;
        in_lsp   = lsp;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("beat_ready_wait", 64'(waited < 20), 64'd1);
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [47:0] data,
                                input logic ovf, input logic [15:0] cnt);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_state"}, 64'(dbg_state), 64'(S_HOLD));
        check({tag, "_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_data"},  64'(out_data), 64'(data));
        check({tag, "_ovf"},   64'(out_overflow), 64'(ovf));
        check({tag, "_count"}, 64'(out_count), 64'(cnt));
    endtask

    // Called at a falling edge while HOLD; takes the result and checks the clear.
    task automatic take_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rel_state"}, 64'(dbg_state), 64'(S_IDLE));
        check({tag, "_rel_count"}, 64'(out_count), 64'd0);
        check({tag, "_rel_data"},  64'(out_data), 64'd0);
        check({tag, "_rel_ovf"},   64'(out_overflow), 64'd0);
        check({tag, "_rel_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_msp    = '0;
        in_lsp    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_state",     64'(dbg_state), 64'(S_IDLE));
        check("rst_count",     64'(out_count), 64'd0);
        check("rst_ovf",       64'(out_overflow), 64'd0);
        check("rst_data",      64'(out_data), 64'd0);
        rst = 1'b0;
        #1 check("rst_rel_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rst_rel_ready_high", 64'(in_ready), 64'd1);

        // LSP carry into MSP
        send_beat(48'h0, 48'h3FFFF, 1'b0);
        idle_cycle();
        check("carry_mid_valid", 64'(out_valid), 64'd0);
        check("carry_mid_state", 64'(dbg_state), 64'(S_ACCUM));
        send_beat(48'h0, 48'h1, 1'b1);
        idle_cycle();
        check_result("carry", 48'h40000, 1'b0, 16'd2);
        take_result("carry");

        // Single-beat frame goes straight to HOLD
        send_beat(48'h5, 48'h7, 1'b1);
        idle_cycle();
        check_result("single", 48'h140007, 1'b0, 16'd1);
        take_result("single");

        // MSP overflow
        send_beat(48'h3FFF_FFFF, 48'h3FFFF, 1'b0);
        send_beat(48'h0, 48'h1, 1'b1);
        idle_cycle();
        check_result("ovf", OVF_DATA, 1'b1, 16'd2);
        take_result("ovf");

        // Backpressure: a waiting beat must not be taken in HOLD or at the handoff
        send_beat(48'h1, 48'h10, 1'b0);
        send_beat(48'h2, 48'h20, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_msp   = 48'h7;
        in_lsp   = 48'h9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data",  64'(out_data), 64'h0C0030);
            check("bp_count", 64'(out_count), 64'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_hand_valid", 64'(out_valid), 64'd0);
        check("bp_hand_state", 64'(dbg_state), 64'(S_IDLE));
        check("bp_hand_count", 64'(out_count), 64'd0);
        check("bp_hand_data",  64'(out_data), 64'd0);
        check("bp_hand_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_next", 48'h1C0009, 1'b0, 16'd1);
        take_result("bp_next");

        // Reset mid-frame discards the partial sum
        send_beat(48'h1, 48'h1, 1'b0);
        send_beat(48'h1, 48'h1, 1'b0);
        send_beat(48'h1, 48'h1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_count", 64'(out_count), 64'd0);
        check("mid_rst_data",  64'(out_data), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        send_beat(48'h0, 48'h2, 1'b1);
        idle_cycle();
        check_result("post_rst", 48'h2, 1'b0, 16'd1);
        take_result("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
